// File: rtl/scalar_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scalar_ctrl_pkg
// Description : Shared sizes and FSM state encoding for scalar_op_controller.
// Revision    : 1.0 - initial release
// ============================================================================
package scalar_ctrl_pkg;

  localparam int N_ELEM = 25;
  localparam int ELEM_W = 8;
  localparam int IDX_W  = 5;
  localparam int FLAT_W = N_ELEM * ELEM_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_EXEC  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/scalar_op_controller.sv
`default_nettype none
// ============================================================================
// Module      : scalar_op_controller
// Description : Job sequencer for the external 25-element matrix-by-scalar ALU:
//               loads A, runs the ALU for one cycle, streams the products out.
//               Optional macro SCALAR_CTRL_OVF_ABORT_EN skips the drain when
//               the ALU reports overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module scalar_op_controller
  import scalar_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        scalar,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [199:0]      alu_a_flat,
  output logic [7:0]        alu_scalar,
  input  logic [199:0]      alu_c_flat,
  input  logic              alu_overflow,
  output logic              busy,
  output logic              done,
  output logic              overflow_flag,
  output logic              ovf_abort
);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [ELEM_W-1:0] r_a [N_ELEM];
  logic [ELEM_W-1:0] r_r [N_ELEM];
  logic [ELEM_W-1:0] r_scalar;
  logic              r_ovf;
  logic              r_done;

  logic              w_last;
  logic              w_abort;
  logic [IDX_W-1:0]  w_idx_next;

  assign w_last     = (r_idx == LAST_IDX);
  // Wrap on the last beat so out_data never reads past R while idle.
  assign w_idx_next = w_last ? '0 : r_idx + 1'b1;

`ifdef SCALAR_CTRL_OVF_ABORT_EN
  assign w_abort = alu_overflow;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_scalar <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      for (int k = 0; k < N_ELEM; k++) begin
        r_a[k] <= '0;
        r_r[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_scalar <= scalar;
            r_ovf    <= 1'b0;
            r_idx    <= '0;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            r_a[r_idx] <= in_data;
            r_idx      <= w_idx_next;
            if (w_last) begin
              r_state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          for (int k = 0; k < N_ELEM; k++) begin
            r_r[k] <= alu_c_flat[k*ELEM_W +: ELEM_W];
          end
          r_ovf <= alu_overflow;
          r_idx <= '0;
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            r_idx <= w_idx_next;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SCALAR_CTRL_OVF_ABORT_EN
  logic r_abort;

  // Pulse aligned with the done that ends an aborted job.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_abort <= 1'b0;
    end else begin
      r_abort <= (r_state == ST_EXEC) && alu_overflow;
    end
  end

  assign ovf_abort = r_abort;
`else
  assign ovf_abort = 1'b0;
`endif

  generate
    for (genvar k = 0; k < N_ELEM; k++) begin : g_pack
      assign alu_a_flat[k*ELEM_W +: ELEM_W] = r_a[k];
    end
  endgenerate

  assign alu_scalar    = r_scalar;
  assign in_ready      = (r_state == ST_LOAD);
  assign out_valid     = (r_state == ST_DRAIN);
  assign out_data      = r_r[r_idx];
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign overflow_flag = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_scalar_op_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_scalar_op_controller
// Description : Self-checking bench for scalar_op_controller with a stand-in
//               scalar ALU and a job-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scalar_op_controller;
  import scalar_ctrl_pkg::*;

`ifdef SCALAR_CTRL_OVF_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   scalar = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic [199:0] alu_a_flat;
  logic [7:0]   alu_scalar;
  logic [199:0] alu_c_flat;
  logic         alu_overflow;
  logic         busy;
  logic         done;
  logic         overflow_flag;
  logic         ovf_abort;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  scalar_op_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .scalar       (scalar),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .alu_a_flat   (alu_a_flat),
    .alu_scalar   (alu_scalar),
    .alu_c_flat   (alu_c_flat),
    .alu_overflow (alu_overflow),
    .busy         (busy),
    .done         (done),
    .overflow_flag(overflow_flag),
    .ovf_abort    (ovf_abort)
  );

  // Signed 8x8 multiply: {overflow, low byte of the product}.
  function automatic logic [8:0] mul8(input logic [7:0] a, input logic [7:0] s);
    int p;
    p = int'($signed(a)) * int'($signed(s));
    return {(p > 127 || p < -128), p[7:0]};
  endfunction

  logic [8:0] alu_t;
  always_comb begin
    alu_c_flat   = '0;
    alu_overflow = 1'b0;
    alu_t        = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      alu_t = mul8(alu_a_flat[k*ELEM_W +: ELEM_W], alu_scalar);
      alu_c_flat[k*ELEM_W +: ELEM_W] = alu_t[7:0];
      alu_overflow = alu_overflow | alu_t[8];
    end
  end

  // Starts a job in the current cycle (may coincide with a previous done) and
  // returns at the cycle where done is observed. Entry/exit: posedge + #1.
  task automatic run_job(input logic [7:0] s, input logic [7:0] a[N_ELEM],
                         input int in_mode, input int out_mode,
                         input bit stray_start, input bit check_timing);
    logic [7:0]        exp_q[$];
    logic [FLAT_W-1:0] exp_flat;
    logic [8:0]        m;
    logic [7:0]        held_d;
    bit                exp_ovf, held_v, seen_done, t_ok;
    int                n_exp, in_cnt, out_cnt, done_k, exp_done_k;
    exp_ovf = 1'b0;
    for (int i = 0; i < N_ELEM; i++) begin
      m = mul8(a[i], s);
      exp_q.push_back(m[7:0]);
      exp_flat[i*ELEM_W +: ELEM_W] = a[i];
      if (m[8]) exp_ovf = 1'b1;
    end
    n_exp      = (ABORT_EN && exp_ovf) ? 0 : N_ELEM;
    exp_done_k = (n_exp == 0) ? 27 : 52;
    in_cnt = 0; out_cnt = 0; held_v = 0; held_d = '0;
    seen_done = 0; t_ok = 1; done_k = 0;
    start = 1'b1; scalar = s; in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 1; k <= 400 && !seen_done; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        n_checks++;
        if (busy === 1'b1 && in_ready === 1'b1 && overflow_flag === 1'b0 &&
            done === 1'b0 && out_valid === 1'b0 && ovf_abort === 1'b0) n_pass++;
        else $display("FAIL job_start busy=%b in_ready=%b ovf=%b done=%b out_valid=%b abort=%b required 1 1 0 0 0 0",
                      busy, in_ready, overflow_flag, done, out_valid, ovf_abort);
      end
      if (check_timing) begin
        if (in_ready !== (k <= 25) ||
            out_valid !== (n_exp > 0 && k >= 27 && k <= 51) ||
            done !== (k == exp_done_k)) begin
          if (t_ok) $display("  timing deviation at T+%0d: in_ready=%b out_valid=%b done=%b", k, in_ready, out_valid, done);
          t_ok = 0;
        end
      end
      if (done === 1'b1) begin
        seen_done = 1; done_k = k;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      end else begin
        start = stray_start && ($urandom_range(0, 3) == 0);
        scalar = start ? 8'($urandom) : s;
        in_valid = (in_cnt < N_ELEM) &&
                   (in_mode == 0 || (in_mode == 1 && (k % 2) == 1) ||
                    (in_mode == 2 && $urandom_range(0, 1) == 1));
        in_data = in_valid ? a[in_cnt] : 8'($urandom);
        if (in_valid && in_ready === 1'b1) in_cnt++;
        out_ready = (out_mode == 0) || (out_mode == 1 && (k % 4) == 3) ||
                    (out_mode == 2 && $urandom_range(0, 2) == 0);
        if (out_valid === 1'b1) begin
          if (held_v) begin
            n_checks++;
            if (out_data === held_d) n_pass++;
            else $display("FAIL stall_hold out_data=%h required %h", out_data, held_d);
          end
          if (out_ready) begin
            n_checks++;
            if (out_cnt < n_exp && out_data === exp_q[out_cnt]) n_pass++;
            else $display("FAIL out_beat idx=%0d out_data=%h required %h (expected beats %0d)",
                          out_cnt, out_data, (out_cnt < N_ELEM) ? exp_q[out_cnt] : 8'h00, n_exp);
            out_cnt++;
            held_v = 0;
          end else begin
            held_v = 1; held_d = out_data;
          end
        end
      end
    end
    n_checks++;
    if (seen_done) n_pass++;
    else begin
      $display("FAIL done_timeout done never seen within 400 cycles");
      rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    end
    n_checks++;
    if (in_cnt == N_ELEM && out_cnt == n_exp) n_pass++;
    else $display("FAIL beat_count in=%0d out=%0d required %0d %0d", in_cnt, out_cnt, N_ELEM, n_exp);
    n_checks++;
    if (overflow_flag === exp_ovf && ovf_abort === (ABORT_EN && exp_ovf)) n_pass++;
    else $display("FAIL ovf_flags overflow_flag=%b ovf_abort=%b required %b %b",
                  overflow_flag, ovf_abort, exp_ovf, ABORT_EN && exp_ovf);
    n_checks++;
    if (alu_scalar === s && alu_a_flat === exp_flat) n_pass++;
    else $display("FAIL alu_operands alu_scalar=%h required %h, alu_a_flat=%h required %h",
                  alu_scalar, s, alu_a_flat, exp_flat);
    if (check_timing) begin
      n_checks++;
      if (t_ok && done_k == exp_done_k) n_pass++;
      else $display("FAIL latency done at T+%0d required T+%0d (cycle profile ok=%0d)", done_k, exp_done_k, t_ok);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; scalar = 8'h5A; in_valid = 1'b1; in_data = 8'hC3; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy === 1'b0 && in_ready === 1'b0 && out_valid === 1'b0 && done === 1'b0) n_pass++;
    else $display("FAIL reset_ctrl busy=%b in_ready=%b out_valid=%b done=%b required 0 0 0 0",
                  busy, in_ready, out_valid, done);
    n_checks++;
    if (out_data === 8'h00 && alu_scalar === 8'h00 && alu_a_flat === '0) n_pass++;
    else $display("FAIL reset_data out_data=%h alu_scalar=%h alu_a_flat=%h required zeros",
                  out_data, alu_scalar, alu_a_flat);
    n_checks++;
    if (overflow_flag === 1'b0 && ovf_abort === 1'b0) n_pass++;
    else $display("FAIL reset_flags overflow_flag=%b ovf_abort=%b required 0 0", overflow_flag, ovf_abort);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy === 1'b0) n_pass++;
    else $display("FAIL idle_no_start busy=%b required 0", busy);
  endtask

  task automatic test_basic();
    logic [7:0] a[N_ELEM];
    for (int i = 0; i < N_ELEM; i++) a[i] = 8'(i + 1);
    run_job(8'd3, a, 0, 0, 0, 1);
  endtask

  task automatic test_overflow();
    logic [7:0] a[N_ELEM];
    @(posedge clk); #1;
    for (int i = 0; i < N_ELEM; i++) a[i] = 8'h01;
    a[7] = 8'h80;
    run_job(8'hFE, a, 0, 0, 0, 1);
  endtask

  // Called right after a job returns, so start coincides with that done.
  task automatic test_back_to_back();
    logic [7:0] a[N_ELEM];
    for (int i = 0; i < N_ELEM; i++) a[i] = 8'($urandom_range(0, 15));
    run_job(8'd5, a, 0, 0, 0, 1);
  endtask

  task automatic test_stalls();
    logic [7:0] a[N_ELEM];
    @(posedge clk); #1;
    for (int i = 0; i < N_ELEM; i++) a[i] = 8'($urandom);
    run_job(8'($urandom_range(0, 255)), a, 1, 1, 1, 0);
  endtask

  task automatic test_mid_reset();
    logic [7:0] a[N_ELEM];
    @(posedge clk); #1;
    start = 1'b1; scalar = 8'h7F;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    repeat (10) begin
      in_data = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy === 1'b0 && in_ready === 1'b0 && done === 1'b0 && out_valid === 1'b0) n_pass++;
    else $display("FAIL midreset_ctrl busy=%b in_ready=%b done=%b out_valid=%b required 0 0 0 0",
                  busy, in_ready, done, out_valid);
    n_checks++;
    if (alu_a_flat === '0 && alu_scalar === 8'h00 && out_data === 8'h00 && overflow_flag === 1'b0) n_pass++;
    else $display("FAIL midreset_data alu_a_flat=%h alu_scalar=%h out_data=%h ovf=%b required zeros",
                  alu_a_flat, alu_scalar, out_data, overflow_flag);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N_ELEM; i++) a[i] = 8'($urandom);
    run_job(8'd1, a, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [7:0] a[N_ELEM];
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N_ELEM; i++) a[i] = 8'($urandom);
      run_job(8'($urandom_range(0, 255)), a, 2, 2, (j % 2) == 1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_stalls();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scalar_op_controller.md
# scalar_op_controller

Sequencer for the 25-element signed 8-bit matrix-by-scalar multiply datapath. It accepts a job start with a scalar and collects matrix A one element per beat over a valid/ready stream. It then drives the combinational scalar-multiply ALU for one cycle, captures the product matrix and the aggregate overflow, and streams the 25 results back out. It sits between the coprocessor's instruction/memory front end and the external scalar ALU, which the parent instantiates and wires to this block's `alu_*` ports.

## Interface
- `N_ELEM`, 25, matrix elements per job (5x5).
- `ELEM_W`, 8, element width in bits.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `scalar`  in  8  signed scalar; latched on the accepted `start`.
- `in_valid` / `in_ready` / `in_data`  in / out / 8  element input stream; element 0 first.
- `out_valid` / `out_ready` / `out_data`  out / in / 8  result output stream; element 0 first.
- `alu_a_flat`  out  200  matrix A to the ALU; element k occupies bits [8k+7:8k].
- `alu_scalar`  out  8  latched scalar to the ALU.
- `alu_c_flat`  in  200  ALU product matrix, same packing as `alu_a_flat`.
- `alu_overflow`  in  1  ALU aggregate overflow.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a job ends.
- `overflow_flag`  out  1  sticky overflow of the last job.
- `ovf_abort`  out  1  qualifies `done`: the job was aborted on overflow.

## Operation
- States: IDLE, LOAD, EXEC, DRAIN.
- IDLE: `start`=1 latches `scalar`, clears `overflow_flag`, `ovf_abort` and the element index, then moves to LOAD.
- LOAD: `in_ready`=1. On each `in_valid&&in_ready`, `in_data` is written to A[idx] and idx increments. The beat with idx=24 moves to EXEC.
- EXEC: one cycle; `alu_a_flat` and `alu_scalar` have been stable since the last load. At the end of the cycle, `alu_c_flat` goes into the result register and `alu_overflow` goes into `overflow_flag`. Next state is DRAIN and idx resets to 0.
- DRAIN: `out_valid`=1 and `out_data`=R[idx]. On each `out_valid&&out_ready`, idx increments. The handshake with idx=24 moves to IDLE and asserts `done` for one cycle.
- `start` outside IDLE is ignored and not queued.
- `start` in the same cycle that `done` is high is accepted, because the state is already IDLE.
- `alu_a_flat` and `alu_scalar` are driven directly from registers and hold their values after the job ends.
- Arithmetic: none in this block. Products, wrap and overflow are defined solely by the ALU; results pass through unmodified.

## Timing
- Reset values: all outputs 0; state IDLE; idx 0; A and R cleared.
- Reset in any state aborts the job at the next edge. No `done` is produced and partial data is discarded.
- Latency with the accepted `start` at cycle T and no stalls:
  - `in_ready` high from T+1 to T+25.
  - EXEC at T+26.
  - First `out_valid` at T+27.
  - Last output handshake at T+51.
  - `done` at T+52.
- Input gaps (`in_valid`=0) and output backpressure (`out_ready`=0) stall idx. `out_data` is held stable while `out_valid&&!out_ready`.
- `overflow_flag` is valid from EXEC+1 until the next accepted `start`.

## Configuration
- `SCALAR_CTRL_OVF_ABORT_EN` defined:
  - If `alu_overflow`=1 in EXEC, the next state is IDLE instead of DRAIN.
  - `done` and `ovf_abort` are both 1 for that one cycle.
  - No output beats are produced; `overflow_flag`=1.
- Not defined:
  - The overflow is only recorded in `overflow_flag`.
  - DRAIN always runs.
  - `ovf_abort` is tied to 0.

## Structure
- Package `scalar_ctrl_pkg` holds:
  - the state enum (IDLE/LOAD/EXEC/DRAIN);
  - `N_ELEM`=25, `ELEM_W`=8, `IDX_W`=5, `FLAT_W`=200.
- No sub-module. The ALU stays outside and is wired by the parent.
- The shared idx counter is the only counter.

## Test plan
- `scalar`=3, A=1..25, no stalls -> outputs 3,6,...,75 in order; `overflow_flag`=0; `done` at T+52.
- `scalar`=-2, A[7]=0x80, rest 0x01 -> out[7]=0x00, others 0xFE; `overflow_flag`=1. With the macro: no `out_valid`; `done`=`ovf_abort`=1 at T+27.
- `in_valid` toggling every cycle and `out_ready` low 3 of 4 cycles -> the same 25 values with no loss or duplication; `out_data` held across stalls.
- `rst_n`=0 after 10 input beats -> next cycle IDLE, all outputs 0. A new job with `scalar`=1 returns its own A unchanged.
- `start` pulsed during LOAD and DRAIN -> ignored. A `start` coincident with `done` -> LOAD on the next cycle, `overflow_flag` cleared.
